// File: rtl/uart_transmitter.sv
// uart_transmitter -- 8N1 UART transmit serializer.
//
// A byte is accepted with a valid/ready handshake while the transmitter is
// idle. It is then sent as one start bit (0), eight data bits LSB first, and
// one stop bit (1). Each bit lasts SYMBOL_EDGE_TIME clock cycles. There is no
// parity bit and only one stop bit. SYMBOL_EDGE_TIME must be at least 2.
//
// Ports
//   clk            single clock; all state changes on the rising edge
//   reset          synchronous, active-high; aborts any frame in flight
//   data_in        byte to transmit
//   data_in_valid  data_in is offered
//   data_in_ready  high only while idle, so a byte can be accepted
//   serial_out     TX line; idle high; driven from a flop
module uart_transmitter #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       tx_byte, tx_byte_next;
    logic             line, line_next;
    logic             symbol_done;

    // Last cycle of the current bit period.
    assign symbol_done = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            tx_byte <= '0;
            line    <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            tx_byte <= tx_byte_next;
            line    <= line_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_idx_next = bit_idx;
        tx_byte_next = tx_byte;

        case (state)
            IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                // Ready is exactly "state is IDLE", so valid alone here
                // completes the handshake.
                if (data_in_valid) begin
                    tx_byte_next = data_in;
                    state_next   = START;
                end
            end
            START: begin
                if (symbol_done) begin
                    cnt_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (symbol_done) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (symbol_done) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // The line level is computed from the next-cycle state and registered,
    // so serial_out changes on the same edge as the state and never glitches
    // on counter compares. tx_byte is held for the whole frame and indexed
    // rather than shifted.
    always_comb begin
        line_next = 1'b1;
        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = tx_byte_next[bit_idx_next];
            default: line_next = 1'b1;
        endcase
    end

    assign data_in_ready = (state == IDLE);
    assign serial_out    = line;

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 SHALL derive localparam SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division): clock cycles per serial bit; 1085 at defaults.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_in  input  8  byte to transmit, from the UART memory-mapped interface TX path.
REQ-007 SHALL have port data_in_valid  input  1  byte on data_in is offered.
REQ-008 SHALL have port data_in_ready  output  1  transmitter can accept a byte.
REQ-009 SHALL have port serial_out  output  1  UART TX line, idle high.

Function
REQ-010 SHALL implement states IDLE, START, DATA, STOP.
REQ-011 SHALL assert data_in_ready if and only if the state is IDLE.
REQ-012 SHALL complete a handshake on a rising edge where data_in_valid=1 and data_in_ready=1, latch data_in into an internal shift register, and move to START.
REQ-013 SHALL ignore data_in and data_in_valid in START, DATA and STOP; the latched byte SHALL NOT change mid-frame.
REQ-014 SHALL drive serial_out=1 in IDLE.
REQ-015 SHALL drive serial_out=0 in START for exactly SYMBOL_EDGE_TIME cycles, starting the cycle after the handshake edge.
REQ-016 SHALL transmit 8 data bits in DATA, LSB first, each held for exactly SYMBOL_EDGE_TIME cycles.
REQ-017 SHALL track the current bit with a 3-bit index 0..7 and leave DATA for STOP after bit 7 completes.
REQ-018 SHALL drive serial_out=1 in STOP for exactly SYMBOL_EDGE_TIME cycles, then return to IDLE.
REQ-019 SHALL hold data_in_ready=0 for exactly 10*SYMBOL_EDGE_TIME cycles after each handshake edge.
REQ-020 SHALL use a cycle counter of width $clog2(SYMBOL_EDGE_TIME). It SHALL count 0..SYMBOL_EDGE_TIME-1 per bit, advance the bit or state on reaching SYMBOL_EDGE_TIME-1, and clear to 0 on every state change.
REQ-021 SHALL give serial_out no glitches: it is driven directly from a register or from state plus register bits, never from combinational counter compares.
REQ-022 SHALL handle back-to-back frames with data_in_valid held high: the next handshake occurs on the first edge with ready=1, and the line is high for SYMBOL_EDGE_TIME+1 cycles between frames.
REQ-023 SHALL have no parity bit and no second stop bit, and SHALL require SYMBOL_EDGE_TIME >= 2.

Reset
REQ-024 SHALL, on the first edge with reset=1, enter IDLE, clear the counters, and set serial_out=1 and data_in_ready=1, independent of data_in_valid.
REQ-025 SHALL, when reset is asserted mid-frame, abort the frame. Line high and ready high apply from the next cycle; the aborted byte SHALL never resume.
REQ-026 SHALL ignore data_in_valid while reset=1; no handshake occurs on that edge.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100, so SYMBOL_EDGE_TIME=10)
REQ-027 SHALL be checked for single byte: data_in=8'h45 with valid for one handshake. Required: serial_out is 0 for 10 cycles, then bits 1,0,1,0,0,0,1,0 at 10 cycles each, then 1 for 10 cycles; ready is low for exactly 100 cycles.
REQ-028 SHALL be checked for busy-ignore: during the frame of 8'h45, apply data_in=8'hFF with valid=1 for 30 cycles, then valid=0. Required: the serialized byte is still 8'h45, and no second frame follows.
REQ-029 SHALL be checked for back-to-back: valid held high with data_in=8'h67 and then 8'hA5 offered on successive handshakes. Required: two frames, the line high for 11 cycles between them, and decoded bytes 8'h67 then 8'hA5.
REQ-030 SHALL be checked for reset mid-frame: reset for 1 cycle during data bit 3 of 8'h00. Required: next cycle serial_out=1 and ready=1; a subsequent 8'h5A handshake produces a clean full frame.
REQ-031 SHALL be checked for idle and reset: after reset with valid=0 for 200 cycles, serial_out stays 1 and ready stays 1 throughout.
REQ-032 SHALL be checked for loopback: serial_out is fed to the team's uart_receiver with the same parameters and bytes 8'h00, 8'hFF, 8'h55, 8'h80 are sent. Required: identical bytes are received in order.
